freq_gate_controller: RTL and testbench

- Measurement sequencer for the frequency meter.
- Generates the counting gate window and counts rising edges of the input signal inside the window. Latches the result and reports overflow.
- Supports single-shot or continuous measurement, with three selectable gate ranges.
- start and range_btn are driven by debounced button outputs; this block edge-detects them itself.

---
 rtl/freq_gate_controller_if.sv | 26 ++
 rtl/freq_gate_controller.sv | 171 +++++++++++++++++
 tb/tb_freq_gate_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_gate_controller_if.sv
// Bus bundle for freq_gate_controller: measurement controls in, result and status out.
// master = controller/stimulus side, slave = the frequency gate block.
interface freq_gate_controller_if #(
   parameter int COUNT_WIDTH = 24
);
   logic                   sig_in;
   logic                   start;
   logic                   cont_mode;
   logic                   range_btn;
   logic [COUNT_WIDTH-1:0] count_out;
   logic [1:0]             range_out;
   logic                   overflow;
   logic                   valid;
   logic                   gate_open;
   logic                   busy;

   modport master (
      output sig_in, start, cont_mode, range_btn,
      input  count_out, range_out, overflow, valid, gate_open, busy
   );

   modport slave (
      input  sig_in, start, cont_mode, range_btn,
      output count_out, range_out, overflow, valid, gate_open, busy
   );
endinterface

// File: rtl/freq_gate_controller.sv
// freq_gate_controller: gate-window sequencer for the frequency meter.
// Counts synchronized rising edges of sig_in during a gate of GATE_BASE,
// GATE_BASE/10 or GATE_BASE/100 clocks, latches a saturating count, then holds
// the result for HOLD_CYCLES before idling or re-measuring (continuous mode).
// Optional macro FREQ_AUTO_RANGE_EN adds automatic range stepping at LATCH.
module freq_gate_controller #(
   parameter int GATE_BASE   = 50000000,
   parameter int HOLD_CYCLES = 5000000,
   parameter int COUNT_WIDTH = 24
) (
   input logic                  clk,
   input logic                  rst,
   freq_gate_controller_if.slave bus
);
   localparam int TMAX = (GATE_BASE > HOLD_CYCLES) ? GATE_BASE : HOLD_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] GATE0_M1 = TW'(GATE_BASE - 1);
   localparam logic [TW-1:0] GATE1_M1 = TW'(GATE_BASE / 10 - 1);
   localparam logic [TW-1:0] GATE2_M1 = TW'(GATE_BASE / 100 - 1);
   localparam logic [TW-1:0] HOLD_M1  = TW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, LATCH, HOLD} state_t;

   state_t                 state_q, state_d;
   logic                   s1_q, s2_q, s3_q;
   logic                   start_q, rbtn_q;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   sat_q, sat_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [1:0]             range_q, range_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q;
   logic                   sig_rise_w, start_rise_w, range_rise_w;
   logic                   gate_open_w, busy_w;

   // Gate length minus one for the selected range (timer preload value).
   function automatic logic [TW-1:0] gate_len_m1(input logic [1:0] r);
      case (r)
         2'd0:    return GATE0_M1;
         2'd1:    return GATE1_M1;
         default: return GATE2_M1;
      endcase
   endfunction

   // Saturating increment: sticks at all-ones.
   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   // Range stepping 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] range_step(input logic [1:0] r);
      return (r == 2'd2) ? 2'd0 : r + 2'd1;
   endfunction

   assign sig_rise_w   = s2_q & ~s3_q;
   assign start_rise_w = bus.start & ~start_q;
   assign range_rise_w = bus.range_btn & ~rbtn_q;

   // Synchronizer for sig_in and history of the debounced button levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         start_q <= 1'b0;
         rbtn_q  <= 1'b0;
      end else begin
         s1_q    <= bus.sig_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         start_q <= bus.start;
         rbtn_q  <= bus.range_btn;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: timer expiry ends GATE and HOLD; cont_mode only matters at HOLD end.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_rise_w) state_d = CLEAR;
         CLEAR:   state_d = GATE;
         GATE:    if (timer_q == '0) state_d = LATCH;
         LATCH:   state_d = HOLD;
         HOLD:    if (timer_q == '0) state_d = bus.cont_mode ? CLEAR : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      gate_open_w = (state_q == GATE);
      busy_w      = (state_q != IDLE);
   end

   // Datapath next-state: counter, timer, range and latched result per FSM state.
   always_comb begin
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      timer_d = timer_q;
      range_d = range_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: if (range_rise_w) range_d = range_step(range_q);
         CLEAR: begin
            cnt_d   = '0;
            sat_d   = 1'b0;
            timer_d = gate_len_m1(range_q);
         end
         GATE: begin
            if (sig_rise_w) begin
               if (&cnt_q) sat_d = 1'b1;
               cnt_d = sat_inc(cnt_q);
            end
            if (timer_q != '0) timer_d = timer_q - TW'(1);
         end
         LATCH: begin
            count_d = cnt_q;
            ovf_d   = sat_q;
            timer_d = HOLD_M1;
`ifdef FREQ_AUTO_RANGE_EN
            // Too many edges: shorten the gate; too few: lengthen it.
            if (sat_q && range_q < 2'd2)
               range_d = range_q + 2'd1;
            else if (cnt_q < COUNT_WIDTH'(10) && range_q != 2'd0)
               range_d = range_q - 2'd1;
`endif
         end
         HOLD: begin
            if (range_rise_w) range_d = range_step(range_q);
            if (timer_q != '0) timer_d = timer_q - TW'(1);
         end
         default: ;
      endcase
   end

   // Datapath registers; reset discards any partial measurement.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         timer_q <= '0;
         range_q <= 2'd0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         timer_q <= timer_d;
         range_q <= range_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= (state_q == LATCH);
      end
   end

   assign bus.count_out = count_q;
   assign bus.range_out = range_q;
   assign bus.overflow  = ovf_q;
   assign bus.valid     = valid_q;
   assign bus.gate_open = gate_open_w;
   assign bus.busy      = busy_w;
endmodule

// File: tb/tb_freq_gate_controller.sv
// Testbench for freq_gate_controller (GATE_BASE=1000, HOLD_CYCLES=4, COUNT_WIDTH=8).
// Table-driven measurements, hand-written corner sequences and randomized
// measurements checked against a cycle-window edge-count model.
module tb_freq_gate_controller;
   localparam int GB = 1000;
   localparam int HC = 4;
   localparam int CW = 8;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   freq_gate_controller_if #(.COUNT_WIDTH(CW)) bus ();
   freq_gate_controller #(.GATE_BASE(GB), .HOLD_CYCLES(HC), .COUNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int sig_per = 10;   // 0 = random bits, otherwise square wave of this period
   int rng_m = 0;      // model of the stored range
   bit hist [0:65535]; // sig_in value driven during each cycle

   typedef struct {
      int presses; int per; int exp_range; int exp_gate; int lo; int hi; int exp_ovf;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic chk_in(input string nm, input int act, input int lo, input int hi);
      n_chk++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
   endtask

   // One clock: outputs are sampled 1 ns after the rising edge, sig_in re-driven.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (sig_per == 0) bus.sig_in = 1'($urandom_range(0, 1));
      else              bus.sig_in = ((cyc % sig_per) < (sig_per / 2));
      if (cyc < 65536) hist[cyc] = bus.sig_in;
   endtask

   function automatic int gate_len(input int r);
      return (r == 0) ? GB : (r == 1) ? GB / 10 : GB / 100;
   endfunction

   // A rise of sig_in driven in cycle j is counted iff j lies in [p, p+gl-1],
   // where p is the cycle in which start was raised (sync latency vs gate offset).
   function automatic int model_rises(input int p, input int gl);
      int n = 0;
      for (int j = p; j < p + gl; j++)
         if (hist[j] && !hist[j-1]) n++;
      return n;
   endfunction

   task automatic press_range();
      bus.range_btn = 1'b1;
      tick();
      bus.range_btn = 1'b0;
      rng_m = (rng_m + 1) % 3;
      tick();
   endtask

   // Full single-shot measurement from IDLE, with optional ignored pokes during
   // GATE and an optional range press in HOLD.
   task automatic run_meas(input string nm, input bit gate_poke, input bit hold_press,
                           output int got_cnt, output int got_ovf, output int got_gate);
      int p, gl, gcnt, vc, n, extra;
      bit seen;
      gl = gate_len(rng_m);
      gcnt = 0; seen = 1'b0; vc = cyc;
      bus.start = 1'b1;
      p = cyc;
      for (int t = 0; t < gl + 20; t++) begin
         tick();
         bus.start = 1'b0;
         bus.range_btn = 1'b0;
         if (bus.gate_open) begin
            gcnt++;
            if (gate_poke && gcnt == gl / 2) begin
               bus.start = 1'b1;
               bus.range_btn = 1'b1;
            end
         end
         if (bus.valid) begin
            seen = 1'b1;
            vc = cyc;
            break;
         end
      end
      got_cnt = int'(bus.count_out);
      got_ovf = int'(bus.overflow);
      got_gate = gcnt;
      chk({nm, "_valid_seen"}, int'(seen), 1);
      if (seen) begin
         n = model_rises(p, gl);
         chk({nm, "_valid_latency"}, cyc - p, gl + 3);
         chk({nm, "_count"}, got_cnt, (n > MAXC) ? MAXC : n);
         chk({nm, "_overflow"}, got_ovf, (n > MAXC) ? 1 : 0);
         chk({nm, "_gate_len"}, gcnt, gl);
         chk({nm, "_range_at_valid"}, int'(bus.range_out), rng_m);
         if (hold_press) begin
            bus.range_btn = 1'b1;
            rng_m = (rng_m + 1) % 3;
         end
         extra = 0;
         for (int t = 0; t < 10 && bus.busy; t++) begin
            tick();
            bus.range_btn = 1'b0;
            if (bus.valid) extra++;
         end
         chk({nm, "_busy_drop_delay"}, cyc - vc, HC);
         chk({nm, "_busy_low"}, int'(bus.busy), 0);
         chk({nm, "_single_valid"}, extra, 0);
         chk({nm, "_range_after"}, int'(bus.range_out), rng_m);
      end
   endtask

   initial begin
      int c, o, g, p0, gl, nval, extra, gcnt, n, k;
      bus.sig_in = 1'b0; bus.start = 1'b0; bus.cont_mode = 1'b0; bus.range_btn = 1'b0;
      rst = 1'b1;
      hist[0] = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_count_out", int'(bus.count_out), 0);
      chk("rst_range_out", int'(bus.range_out), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_gate_open", int'(bus.gate_open), 0);
      chk("rst_busy", int'(bus.busy), 0);
      rst = 1'b0;
      tick();

      // Table: range presses, sig period, expected range/gate/count window/overflow
      tbl[0] = '{0, 10, 0, 1000, 99, 100, 0};
      tbl[1] = '{1, 10, 1, 100, 9, 10, 0};
      tbl[2] = '{1, 10, 2, 10, 1, 1, 0};
      tbl[3] = '{1, 2, 0, 1000, 255, 255, 1};
      tbl[4] = '{0, 10, 0, 1000, 99, 100, 0};
      tbl[5] = '{3, 4, 0, 1000, 250, 250, 0};
      for (int i = 0; i < 6; i++) begin
         repeat (tbl[i].presses) press_range();
         chk($sformatf("vec%0d_range", i), int'(bus.range_out), tbl[i].exp_range);
         sig_per = tbl[i].per;
         run_meas($sformatf("vec%0d", i), 1'b0, 1'b0, c, o, g);
         chk_in($sformatf("vec%0d_count_tbl", i), c, tbl[i].lo, tbl[i].hi);
         chk($sformatf("vec%0d_ovf_tbl", i), o, tbl[i].exp_ovf);
         chk($sformatf("vec%0d_gate_tbl", i), g, tbl[i].exp_gate);
      end

      // start and range_btn during GATE are ignored; range_btn in HOLD is taken
      sig_per = 10;
      run_meas("gate_poke", 1'b1, 1'b1, c, o, g);
      chk("gate_poke_gate_1000", g, 1000);
      chk("hold_press_range1", int'(bus.range_out), 1);

      // Reset in the middle of GATE
      sig_per = 7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      gcnt = 0;
      for (int t = 0; t < 400 && gcnt < 50; t++) begin
         tick();
         if (bus.gate_open) gcnt++;
      end
      chk("midgate_reached", gcnt, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rng_m = 0;
      chk("midrst_gate_open", int'(bus.gate_open), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_count_out", int'(bus.count_out), 0);
      chk("midrst_range_out", int'(bus.range_out), 0);
      chk("midrst_valid", int'(bus.valid), 0);
      tick();
      run_meas("after_rst", 1'b0, 1'b0, c, o, g);

      // Continuous mode, random sig_in; cont_mode dropped inside the third gate
      sig_per = 0;
      gl = gate_len(rng_m);
      bus.cont_mode = 1'b1;
      bus.start = 1'b1;
      p0 = cyc;
      nval = 0;
      for (int t = 0; t < 4000; t++) begin
         tick();
         bus.start = 1'b0;
         if (cyc == p0 + 2 * (gl + 6) + 2 + 500) bus.cont_mode = 1'b0;
         if (bus.valid) begin
            k = nval;
            chk($sformatf("cont_valid%0d_time", k), cyc, p0 + 3 + gl + k * (gl + 6));
            n = model_rises(p0 + k * (gl + 6), gl);
            chk($sformatf("cont_valid%0d_count", k), int'(bus.count_out), (n > MAXC) ? MAXC : n);
            chk($sformatf("cont_valid%0d_ovf", k), int'(bus.overflow), (n > MAXC) ? 1 : 0);
            nval++;
         end
         if (!bus.busy && t > 2) break;
      end
      chk("cont_valid_total", nval, 3);
      chk("cont_idle_busy", int'(bus.busy), 0);
      extra = 0;
      for (int t = 0; t < 30; t++) begin
         tick();
         if (bus.valid || bus.busy) extra++;
      end
      chk("cont_stays_idle", extra, 0);

      // Randomized measurements against the model
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 2)) press_range();
         chk($sformatf("rnd%0d_range", i), int'(bus.range_out), rng_m);
         sig_per = $urandom_range(0, 12);
         run_meas($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), c, o, g);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
